// File: rtl/sw_pkg.sv
// Shared types, constants and index helpers for the stride-permutation stage.
package sw_pkg;

  localparam int unsigned SW_WIDTH = 32;

  // Two-state engine used by both the fill and the read side.
  typedef enum logic {
    ENG_IDLE   = 1'b0,
    ENG_ACTIVE = 1'b1
  } eng_state_t;

  // Ceiling log2, for elaboration-time sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Source index for output index k of a stride-2 permutation of 2*depth words:
  // even inputs first, then odd inputs.
  function automatic int unsigned stride_src(input int unsigned k, input int unsigned depth);
    return (k < depth) ? (2 * k) : (2 * (k - depth) + 1);
  endfunction

endpackage

// File: rtl/sw_stride_perm_mem_if.sv
// Two-lane streaming bus: block start + input pair in, block start + output pair out.
interface sw_stride_perm_mem_if
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH
);
  logic             next;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] x1;
  logic             next_out;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic             overrun;

  // Upstream side: produces the input stream, observes the permuted stream.
  modport master (
    output next, x0, x1,
    input  next_out, y0, y1, overrun
  );

  // Permutation stage side.
  modport slave (
    input  next, x0, x1,
    output next_out, y0, y1, overrun
  );
endinterface

// File: rtl/sw_perm_buffer.sv
// One 2*DEPTH x WIDTH register bank: paired write at 2c/2c+1, two async reads.
module sw_perm_buffer
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH     = SW_WIDTH,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOG_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [LOG_DEPTH-1:0] i_wcnt,
  input  logic [WIDTH-1:0]     i_d0,
  input  logic [WIDTH-1:0]     i_d1,
  input  logic [LOG_DEPTH:0]   i_ra0,
  input  logic [LOG_DEPTH:0]   i_ra1,
  output logic [WIDTH-1:0]     o_q0,
  output logic [WIDTH-1:0]     o_q1
);
  logic [WIDTH-1:0] r_mem [2*DEPTH];

  // Store the incoming pair; contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[{i_wcnt, 1'b0}] <= i_d0;
      r_mem[{i_wcnt, 1'b1}] <= i_d1;
    end
  end

  assign o_q0 = r_mem[i_ra0];
  assign o_q1 = r_mem[i_ra1];
endmodule

// File: rtl/sw_stride_perm_mem.sv
// Streaming stride-2 permutation (even words then odd words) over ping-pong buffers.
module sw_stride_perm_mem
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH     = SW_WIDTH,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOG_DEPTH = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sw_stride_perm_mem_if.slave  bus
);
  localparam int unsigned          AW   = LOG_DEPTH + 1;
  localparam logic [LOG_DEPTH-1:0] LAST = LOG_DEPTH'(DEPTH - 1);

  eng_state_t           r_fill_st;
  eng_state_t           r_rd_st;
  logic [LOG_DEPTH-1:0] r_fill_cnt;
  logic [LOG_DEPTH-1:0] r_rd_cnt;
  logic                 r_wsel;
  logic                 r_next_out;
  logic                 r_overrun;
  logic [WIDTH-1:0]     r_y0;
  logic [WIDTH-1:0]     r_y1;

  logic                 w_fill_last;
  logic                 w_accept;
  logic                 w_reject;
  logic [AW-1:0]        w_ra0;
  logic [AW-1:0]        w_ra1;
  logic [WIDTH-1:0]     w_b0_q0, w_b0_q1, w_b1_q0, w_b1_q1;
  logic [WIDTH-1:0]     w_q0, w_q1;

  assign w_fill_last = (r_fill_st == ENG_ACTIVE) && (r_fill_cnt == LAST);
  assign w_accept    = bus.next && ((r_fill_st == ENG_IDLE) || w_fill_last);
  assign w_reject    = bus.next && !w_accept;

  // Read cycle r emits output indices 2r and 2r+1.
  assign w_ra0 = AW'(stride_src(32'({r_rd_cnt, 1'b0}), DEPTH));
  assign w_ra1 = AW'(stride_src(32'({r_rd_cnt, 1'b1}), DEPTH));

  sw_perm_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) u_buf0 (
    .i_clk (clk),
    .i_we  ((r_fill_st == ENG_ACTIVE) && !r_wsel),
    .i_wcnt(r_fill_cnt),
    .i_d0  (bus.x0),
    .i_d1  (bus.x1),
    .i_ra0 (w_ra0),
    .i_ra1 (w_ra1),
    .o_q0  (w_b0_q0),
    .o_q1  (w_b0_q1)
  );

  sw_perm_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) u_buf1 (
    .i_clk (clk),
    .i_we  ((r_fill_st == ENG_ACTIVE) && r_wsel),
    .i_wcnt(r_fill_cnt),
    .i_d0  (bus.x0),
    .i_d1  (bus.x1),
    .i_ra0 (w_ra0),
    .i_ra1 (w_ra1),
    .o_q0  (w_b1_q0),
    .o_q1  (w_b1_q1)
  );

  // The read side always drains the buffer not currently being filled.
  assign w_q0 = r_wsel ? w_b0_q0 : w_b1_q0;
  assign w_q1 = r_wsel ? w_b0_q1 : w_b1_q1;

  // Fill engine: accepts next when idle or in its last cycle, flips wsel at block end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_st  <= ENG_IDLE;
      r_fill_cnt <= '0;
      r_wsel     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= w_reject;
      if (w_fill_last) r_wsel <= ~r_wsel;
      if (w_accept) begin
        r_fill_st  <= ENG_ACTIVE;
        r_fill_cnt <= '0;
      end else if (w_fill_last) begin
        r_fill_st  <= ENG_IDLE;
        r_fill_cnt <= '0;
      end else if (r_fill_st == ENG_ACTIVE) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
    end
  end

  // Read engine: starts on fill handoff (restarting seamlessly), registers outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_st    <= ENG_IDLE;
      r_rd_cnt   <= '0;
      r_next_out <= 1'b0;
      r_y0       <= '0;
      r_y1       <= '0;
    end else begin
      r_next_out <= w_fill_last;
      if (r_rd_st == ENG_ACTIVE) begin
        r_y0 <= w_q0;
        r_y1 <= w_q1;
      end
      if (w_fill_last) begin
        r_rd_st  <= ENG_ACTIVE;
        r_rd_cnt <= '0;
      end else if ((r_rd_st == ENG_ACTIVE) && (r_rd_cnt == LAST)) begin
        r_rd_st  <= ENG_IDLE;
        r_rd_cnt <= '0;
      end else if (r_rd_st == ENG_ACTIVE) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  assign bus.next_out = r_next_out;
  assign bus.overrun  = r_overrun;
  assign bus.y0       = r_y0;
  assign bus.y1       = r_y1;
endmodule

// File: tb/tb_sw_stride_perm_mem.sv
// Directed bench for sw_stride_perm_mem at DEPTH=4 and DEPTH=8.
module tb_sw_stride_perm_mem;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sw_stride_perm_mem_if #(.WIDTH(32)) if4 ();
  sw_stride_perm_mem_if #(.WIDTH(32)) if8 ();

  sw_stride_perm_mem #(.WIDTH(32), .DEPTH(4), .LOG_DEPTH(2)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if4)
  );

  sw_stride_perm_mem #(.WIDTH(32), .DEPTH(8), .LOG_DEPTH(3)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One DEPTH=4 cycle: drive inputs, check outputs visible this cycle, advance.
  task automatic s4(input logic n, input logic [31:0] a, input logic [31:0] b,
                    input logic eno, input logic eov, input logic [31:0] e0, input logic [31:0] e1);
    if4.next = n;
    if4.x0   = a;
    if4.x1   = b;
    chk("d4.next_out", 32'(if4.next_out), 32'(eno));
    chk("d4.overrun",  32'(if4.overrun),  32'(eov));
    chk("d4.y0",       if4.y0, e0);
    chk("d4.y1",       if4.y1, e1);
    @(posedge clk);
    #1;
  endtask

  // One DEPTH=8 cycle.
  task automatic s8(input logic n, input logic [31:0] a, input logic [31:0] b,
                    input logic eno, input logic [31:0] e0, input logic [31:0] e1);
    if8.next = n;
    if8.x0   = a;
    if8.x1   = b;
    chk("d8.next_out", 32'(if8.next_out), 32'(eno));
    chk("d8.overrun",  32'(if8.overrun),  32'd0);
    chk("d8.y0",       if8.y0, e0);
    chk("d8.y1",       if8.y1, e1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if4.next = 1'b0; if4.x0 = '0; if4.x1 = '0;
    if8.next = 1'b0; if8.x0 = '0; if8.x1 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst.next_out", 32'(if4.next_out), 32'd0);
    chk("rst.overrun",  32'(if4.overrun),  32'd0);
    chk("rst.y0",       if4.y0, 32'd0);
    chk("rst.y1",       if4.y1, 32'd0);
    chk("rst.d8.y0",    if8.y0, 32'd0);
    rst_n = 1'b1;

    // Idle: 20 cycles without next
    for (int i = 0; i < 20; i++) begin
      chk("idle.d8.next_out", 32'(if8.next_out), 32'd0);
      chk("idle.d8.y1",       if8.y1, 32'd0);
      s4(0, 0, 0, 0, 0, 0, 0);
    end

    // Single block 0..7
    s4(1, 0, 0, 0, 0, 0, 0);
    s4(0, 0, 1, 0, 0, 0, 0);
    s4(0, 2, 3, 0, 0, 0, 0);
    s4(0, 4, 5, 0, 0, 0, 0);
    s4(0, 6, 7, 0, 0, 0, 0);
    s4(0, 0, 0, 1, 0, 0, 0);
    s4(0, 0, 0, 0, 0, 0, 2);
    s4(0, 0, 0, 0, 0, 4, 6);
    s4(0, 0, 0, 0, 0, 1, 3);
    s4(0, 0, 0, 0, 0, 5, 7);
    s4(0, 0, 0, 0, 0, 5, 7);
    s4(0, 0, 0, 0, 0, 5, 7);

    // Back-to-back: 0..7 then 10..17, second next in last fill cycle
    s4(1, 0,  0,  0, 0, 5,  7);
    s4(0, 0,  1,  0, 0, 5,  7);
    s4(0, 2,  3,  0, 0, 5,  7);
    s4(0, 4,  5,  0, 0, 5,  7);
    s4(1, 6,  7,  0, 0, 5,  7);
    s4(0, 10, 11, 1, 0, 5,  7);
    s4(0, 12, 13, 0, 0, 0,  2);
    s4(0, 14, 15, 0, 0, 4,  6);
    s4(0, 16, 17, 0, 0, 1,  3);
    s4(0, 0,  0,  1, 0, 5,  7);
    s4(0, 0,  0,  0, 0, 10, 12);
    s4(0, 0,  0,  0, 0, 14, 16);
    s4(0, 0,  0,  0, 0, 11, 13);
    s4(0, 0,  0,  0, 0, 15, 17);
    s4(0, 0,  0,  0, 0, 15, 17);

    // Overrun: second next two cycles into the fill is rejected
    s4(1, 0,  0,  0, 0, 15, 17);
    s4(0, 20, 21, 0, 0, 15, 17);
    s4(1, 22, 23, 0, 0, 15, 17);
    s4(0, 24, 25, 0, 1, 15, 17);
    s4(0, 26, 27, 0, 0, 15, 17);
    s4(0, 0,  0,  1, 0, 15, 17);
    s4(0, 0,  0,  0, 0, 20, 22);
    s4(0, 0,  0,  0, 0, 24, 26);
    s4(0, 0,  0,  0, 0, 21, 23);
    s4(0, 0,  0,  0, 0, 25, 27);
    s4(0, 0,  0,  0, 0, 25, 27);
    s4(0, 0,  0,  0, 0, 25, 27);

    // Reset in the middle of the read phase
    s4(1, 0,  0,  0, 0, 25, 27);
    s4(0, 30, 31, 0, 0, 25, 27);
    s4(0, 32, 33, 0, 0, 25, 27);
    s4(0, 34, 35, 0, 0, 25, 27);
    s4(0, 36, 37, 0, 0, 25, 27);
    s4(0, 0,  0,  1, 0, 25, 27);
    s4(0, 0,  0,  0, 0, 30, 32);
    rst_n = 1'b0;
    #1;
    chk("midrst.y0",       if4.y0, 32'd0);
    chk("midrst.y1",       if4.y1, 32'd0);
    chk("midrst.next_out", 32'(if4.next_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) s4(0, 0, 0, 0, 0, 0, 0);

    // Fresh block after reset
    s4(1, 0,  0,  0, 0, 0,  0);
    s4(0, 40, 41, 0, 0, 0,  0);
    s4(0, 42, 43, 0, 0, 0,  0);
    s4(0, 44, 45, 0, 0, 0,  0);
    s4(0, 46, 47, 0, 0, 0,  0);
    s4(0, 0,  0,  1, 0, 0,  0);
    s4(0, 0,  0,  0, 0, 40, 42);
    s4(0, 0,  0,  0, 0, 44, 46);
    s4(0, 0,  0,  0, 0, 41, 43);
    s4(0, 0,  0,  0, 0, 45, 47);
    s4(0, 0,  0,  0, 0, 45, 47);

    // DEPTH=8 block 0..15
    s8(1, 0,  0,  0, 0,  0);
    s8(0, 0,  1,  0, 0,  0);
    s8(0, 2,  3,  0, 0,  0);
    s8(0, 4,  5,  0, 0,  0);
    s8(0, 6,  7,  0, 0,  0);
    s8(0, 8,  9,  0, 0,  0);
    s8(0, 10, 11, 0, 0,  0);
    s8(0, 12, 13, 0, 0,  0);
    s8(0, 14, 15, 0, 0,  0);
    s8(0, 0,  0,  1, 0,  0);
    s8(0, 0,  0,  0, 0,  2);
    s8(0, 0,  0,  0, 4,  6);
    s8(0, 0,  0,  0, 8,  10);
    s8(0, 0,  0,  0, 12, 14);
    s8(0, 0,  0,  0, 1,  3);
    s8(0, 0,  0,  0, 5,  7);
    s8(0, 0,  0,  0, 9,  11);
    s8(0, 0,  0,  0, 13, 15);
    s8(0, 0,  0,  0, 13, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
